interrupt_sequencer: RTL

- Sequences hardware interrupt entry and RTI return for the 16-bit pipelined processor.
- On an accepted interrupt it freezes fetch and drains the pipeline. It then pushes PC and the {C,N,Z} flags through the memory stage and redirects the PC to the handler vector.
- On RTI it pops the flags and PC back in reverse order and restores flags through the ALU flag-register path (flag source select plus popped condition bits).
- It sits beside decode/execute and borrows the memory stage only when that stage is idle.

---
 rtl/intc_pkg.sv | 36 +++
 rtl/interrupt_sequencer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt sequencer: state codes, word widths,
// flag field layout and small state-class helpers.
package intc_pkg;

   localparam int DATA_W = 16;
   localparam int FLAG_W = 3;

   // Flag word layout {C,N,Z}; bits above FLAG_W are zero on the stack.
   localparam int FL_C = 2;
   localparam int FL_N = 1;
   localparam int FL_Z = 0;

   // Entry pushes PC high, PC low, flags; return pops them in reverse.
   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_DRAIN   = 4'd1;
   localparam logic [3:0] S_PUSH_HI = 4'd2;
   localparam logic [3:0] S_PUSH_LO = 4'd3;
   localparam logic [3:0] S_PUSH_FL = 4'd4;
   localparam logic [3:0] S_VECTOR  = 4'd5;
   localparam logic [3:0] S_POP_FL  = 4'd6;
   localparam logic [3:0] S_WAIT_FL = 4'd7;
   localparam logic [3:0] S_POP_LO  = 4'd8;
   localparam logic [3:0] S_WAIT_LO = 4'd9;
   localparam logic [3:0] S_POP_HI  = 4'd10;
   localparam logic [3:0] S_WAIT_HI = 4'd11;
   localparam logic [3:0] S_RESUME  = 4'd12;

   function automatic logic is_push(input logic [3:0] s);
      return (s == S_PUSH_HI) || (s == S_PUSH_LO) || (s == S_PUSH_FL);
   endfunction

   function automatic logic is_pop(input logic [3:0] s);
      return (s == S_POP_FL) || (s == S_POP_LO) || (s == S_POP_HI);
   endfunction

endpackage

// File: rtl/interrupt_sequencer.sv
// Interrupt entry / RTI return sequencer. Freezes fetch, drains the pipe,
// pushes PC and flags through the idle memory stage, redirects to the
// handler vector, and on RTI pops everything back and restores flags.
module interrupt_sequencer #(
   parameter int PC_W         = 32,
   parameter int DATA_W       = intc_pkg::DATA_W,
   parameter int DRAIN_CYCLES = 3,
   parameter logic [PC_W-1:0] INT_VECTOR = PC_W'(32'h0000_0020)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              int_req,
   input  logic              rti_ex,
   input  logic [PC_W-1:0]   pc_return,
   input  logic [2:0]        flags_cur,
   input  logic              mem_busy,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall_fe,
   output logic              mem_push,
   output logic              mem_pop,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              flag_regsel,
   output logic [2:0]        flags_pop,
   output logic              pc_load,
   output logic [PC_W-1:0]   pc_load_value,
   output logic              busy,
   output logic              int_ack
);
   import intc_pkg::*;

   localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   logic [3:0]        state;
   logic              pending;
   logic              in_handler;
   logic [PC_W-1:0]   ret_pc;     // captured on entry, reassembled on return
   logic [FLAG_W-1:0] saved_fl;
   logic [FLAG_W-1:0] fl_pop_q;
   logic              regsel_q;
   logic [CNT_W-1:0]  drain_cnt;
   logic              accept;
   logic              cap_fl;

   // RTI has priority; the interrupt stays pending and is taken later.
   assign accept = (state == S_IDLE) && !rti_ex && pending && !in_handler;
   assign cap_fl = (state == S_WAIT_FL) && mem_rvalid;

   // Sequencer state, pending/mask bits, captured context and pop data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         pending    <= 1'b0;
         in_handler <= 1'b0;
         ret_pc     <= '0;
         saved_fl   <= '0;
         fl_pop_q   <= '0;
         regsel_q   <= 1'b0;
         drain_cnt  <= '0;
      end else begin
         // A request on the accept edge re-arms pending rather than being lost.
         pending  <= int_req | (pending & ~accept);
         regsel_q <= cap_fl;
         case (state)
            S_IDLE: begin
               if (rti_ex) begin
                  state <= S_POP_FL;
               end else if (accept) begin
                  ret_pc    <= pc_return;
                  saved_fl  <= flags_cur;
                  drain_cnt <= '0;
                  state     <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (drain_cnt == CNT_W'(DRAIN_CYCLES - 1)) state <= S_PUSH_HI;
               else drain_cnt <= drain_cnt + 1'b1;
            end
            S_PUSH_HI: if (!mem_busy) state <= S_PUSH_LO;
            S_PUSH_LO: if (!mem_busy) state <= S_PUSH_FL;
            S_PUSH_FL: if (!mem_busy) state <= S_VECTOR;
            S_VECTOR: begin
               in_handler <= 1'b1;
               state      <= S_IDLE;
            end
            S_POP_FL: if (!mem_busy) state <= S_WAIT_FL;
            S_WAIT_FL: begin
               if (mem_rvalid) begin
                  fl_pop_q <= mem_rdata[FLAG_W-1:0];
                  state    <= S_POP_LO;
               end
            end
            S_POP_LO: if (!mem_busy) state <= S_WAIT_LO;
            S_WAIT_LO: begin
               if (mem_rvalid) begin
                  ret_pc[DATA_W-1:0] <= mem_rdata;
                  state              <= S_POP_HI;
               end
            end
            S_POP_HI: if (!mem_busy) state <= S_WAIT_HI;
            S_WAIT_HI: begin
               if (mem_rvalid) begin
                  ret_pc[PC_W-1:DATA_W] <= mem_rdata;
                  state                 <= S_RESUME;
               end
            end
            S_RESUME: begin
               in_handler <= 1'b0;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Outputs decoded from state; push/pop additionally gate on mem_busy.
   always_comb begin
      stall_fe      = (state != S_IDLE);
      busy          = (state != S_IDLE);
      mem_push      = is_push(state) && !mem_busy;
      mem_pop       = is_pop(state) && !mem_busy;
      int_ack       = accept;
      pc_load       = (state == S_VECTOR) || (state == S_RESUME);
      // Regsel spans the capture cycle and the next, so the flag register
      // sees a whole negedge with the popped value on flags_pop.
      flag_regsel   = cap_fl | regsel_q;
      flags_pop     = cap_fl ? mem_rdata[FLAG_W-1:0] : fl_pop_q;
      mem_wdata     = '0;
      pc_load_value = '0;
      case (state)
         S_PUSH_HI: mem_wdata = ret_pc[PC_W-1:DATA_W];
         S_PUSH_LO: mem_wdata = ret_pc[DATA_W-1:0];
         S_PUSH_FL: mem_wdata = {{(DATA_W-FLAG_W){1'b0}}, saved_fl};
         S_VECTOR:  pc_load_value = INT_VECTOR;
         S_RESUME:  pc_load_value = ret_pc;
         default: ;
      endcase
   end

endmodule
